ascii_bin_arbiter: RTL and testbench

Round-robin front end that shares one ASCII-decimal-to-binary converter among NUM_REQ character sources. Each source delivers one decimal number as a burst of ASCII digit characters. The arbiter grants one source, buffers its digits, left-pads the number with '0' to DIGITS_LENGTH characters, and streams it to the converter on consecutive cycles. It then captures the binary result and returns it, tagged with the source ID, over a valid/ready result port.

---
 rtl/ascii2bin_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/ascii_bin_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ascii_bin_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii2bin_pkg.sv
// rtl/ascii2bin_pkg.sv - shared types and ASCII helpers for the ASCII-to-binary arbiter
package ascii2bin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    STREAM,
    WAIT,
    RESULT
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the requesters from rr_ptr upward with wrap; first active one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ascii_bin_arbiter.sv
// rtl/ascii_bin_arbiter.sv - round-robin front end sharing one ASCII-decimal converter
module ascii_bin_arbiter
  import ascii2bin_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int DIGITS_LENGTH = 8,
  parameter int CONV_LAT      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*8-1:0]         req_char,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         conv_valid,
  output logic [7:0]                   conv_char,
  input  logic                         conv_busy,
  input  logic [DIGITS_LENGTH*4-1:0]   conv_result,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [DIGITS_LENGTH*4-1:0]   res_data,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
  output logic                         res_err
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(DIGITS_LENGTH + 1);
  localparam int POS_W  = (DIGITS_LENGTH > 1) ? $clog2(DIGITS_LENGTH) : 1;
  localparam int WCNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam int BUF_W  = DIGITS_LENGTH * 8;

  state_t              state, state_next;
  logic [IDX_W-1:0]    grant, rr_ptr, arb_idx;
  logic [NUM_REQ-1:0]  arb_onehot;
  logic [CNT_W-1:0]    cnt;
  logic                err;
  logic [BUF_W-1:0]    dig_buf, buf_in;
  logic [POS_W-1:0]    pos;
  logic [WCNT_W-1:0]   wcnt;
  logic [7:0]          src_chars [NUM_REQ];
  logic [7:0]          cur_char, store_char;
  logic                cur_last, char_ok, char_fits;
  logic                start_grant, char_accept, stream_end, wait_end, res_taken;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chars
    assign src_chars[g] = req_char[8*g +: 8];
  end

  assign cur_char   = src_chars[grant];
  assign cur_last   = req_last[grant];
  assign char_ok    = is_digit(cur_char);
  assign store_char = char_ok ? cur_char : ASCII_ZERO;
  assign char_fits  = cnt < CNT_W'(DIGITS_LENGTH);
  // The buffer is pre-filled with '0' and shifted left per digit, so the
  // number ends up right-aligned and already left-padded for streaming.
  assign buf_in     = (char_accept && char_fits) ? ((dig_buf << 8) | BUF_W'(store_char)) : dig_buf;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_onehot),
    .grant_idx (arb_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode, handshake strobes and the req_ready decode.
  always_comb begin
    state_next  = state;
    req_ready   = '0;
    start_grant = 1'b0;
    char_accept = 1'b0;
    stream_end  = 1'b0;
    wait_end    = 1'b0;
    res_taken   = 1'b0;
    case (state)
      IDLE: if (|arb_onehot && !conv_busy) begin
        start_grant = 1'b1;
        state_next  = COLLECT;
      end
      COLLECT: begin
        req_ready[grant] = 1'b1;
        char_accept      = req_valid[grant];
        if (char_accept && cur_last) state_next = STREAM;
      end
      STREAM: if (pos == POS_W'(DIGITS_LENGTH - 1)) begin
        stream_end = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (wcnt == WCNT_W'(CONV_LAT - 1)) begin
        wait_end   = 1'b1;
        state_next = RESULT;
      end
      RESULT: if (res_ready) begin
        res_taken  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: grant capture, digit buffering, streaming, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      dig_buf    <= '0;
      pos        <= '0;
      wcnt       <= '0;
      conv_valid <= 1'b0;
      conv_char  <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= '0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_grant) begin
          grant   <= arb_idx;
          cnt     <= '0;
          err     <= 1'b0;
          dig_buf <= {DIGITS_LENGTH{ASCII_ZERO}};
        end
        COLLECT: if (char_accept) begin
          if (char_fits) begin
            cnt <= cnt + 1'b1;
            if (!char_ok) err <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          if (cur_last) begin
            conv_valid <= 1'b1;
            conv_char  <= buf_in[BUF_W-1 -: 8];
            dig_buf    <= buf_in << 8;
            pos        <= '0;
          end else begin
            dig_buf <= buf_in;
          end
        end
        STREAM: if (stream_end) begin
          conv_valid <= 1'b0;
          conv_char  <= '0;
          wcnt       <= '0;
        end else begin
          conv_char <= dig_buf[BUF_W-1 -: 8];
          dig_buf   <= dig_buf << 8;
          pos       <= pos + 1'b1;
        end
        WAIT: if (wait_end) begin
          res_valid <= 1'b1;
          res_data  <= conv_result;
          res_id    <= grant;
          res_err   <= err;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
        RESULT: if (res_taken) begin
          res_valid <= 1'b0;
          rr_ptr    <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_bin_arbiter.sv
// tb/tb_ascii_bin_arbiter.sv - self-checking bench for ascii_bin_arbiter
module tb_ascii_bin_arbiter;

  localparam int D  = 8;
  localparam int CL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_char = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic        conv_valid;
  logic [7:0]  conv_char;
  logic        conv_busy = 1'b0;
  logic [31:0] conv_result;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        res_id;
  logic        res_err;

  always #5 clk = ~clk;

  ascii_bin_arbiter #(.NUM_REQ(2), .DIGITS_LENGTH(D), .CONV_LAT(CL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_char(req_char), .req_last(req_last), .req_ready(req_ready),
    .conv_valid(conv_valid), .conv_char(conv_char), .conv_busy(conv_busy), .conv_result(conv_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .res_err(res_err)
  );

  // Behavioural converter: accumulate decimal digits while conv_valid is high.
  logic [31:0] conv_acc = '0;
  logic        conv_prev = 1'b0;
  always @(posedge clk) begin
    if (conv_valid) conv_acc <= (conv_prev ? conv_acc * 10 : 32'd0) + 32'(conv_char - 8'h30);
    conv_prev <= conv_valid;
  end
  assign conv_result = conv_acc;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int res_cyc = 0;
  bit stall_en = 1'b0;

  typedef struct {
    logic [31:0] val;
    logic        err;
    logic [63:0] strm;
  } exp_t;

  exp_t        e0[$], e1[$];
  logic [8:0]  q0[$], q1[$];
  logic [7:0]  cur[$];
  logic [7:0]  conv_seen[$];
  bit          acc0 = 1'b0, acc1 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source drivers plus per-cycle protocol monitor.
  always @(negedge clk) begin
    cyc++;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
      req_valid[0] = 1'b1; req_char[7:0] = q0[0][7:0]; req_last[0] = q0[0][8];
    end else begin
      req_valid[0] = 1'b0; req_char[7:0] = 8'h00; req_last[0] = 1'b0;
    end
    if (q1.size() > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
      req_valid[1] = 1'b1; req_char[15:8] = q1[0][7:0]; req_last[1] = q1[0][8];
    end else begin
      req_valid[1] = 1'b0; req_char[15:8] = 8'h00; req_last[1] = 1'b0;
    end
    acc0 = req_valid[0] && req_ready[0];
    acc1 = req_valid[1] && req_ready[1];
    if ((acc0 && req_last[0]) || (acc1 && req_last[1])) last_acc_cyc = cyc;
    if (rst_n) begin
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (conv_valid || res_valid) chk("ready_held_off", 64'(req_ready), 64'd0);
      if (conv_valid) conv_seen.push_back(conv_char);
    end
  end

  task automatic load_str(input string s);
    cur.delete();
    for (int i = 0; i < s.len(); i++) cur.push_back(s[i]);
  endtask

  task automatic gen_random();
    logic [7:0] bad [4];
    int n;
    bad[0] = 8'h2F; bad[1] = 8'h3A; bad[2] = 8'h41; bad[3] = 8'h20;
    cur.delete();
    n = $urandom_range(1, 10);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 19) == 0) cur.push_back(bad[$urandom_range(0, 3)]);
      else cur.push_back(8'(8'h30 + $urandom_range(0, 9)));
    end
  endtask

  // Reference: keep the first D characters, non-digits read as '0',
  // pad on the left with '0' to D characters.
  task automatic enqueue(input int src);
    exp_t e;
    logic [7:0] kept[$];
    logic [7:0] c;
    int n = cur.size();
    int pad;
    e.val = '0;
    e.err = (n > D);
    e.strm = '0;
    for (int i = 0; i < n; i++) begin
      if (i < D) begin
        c = cur[i];
        if (c < 8'h30 || c > 8'h39) begin e.err = 1'b1; c = 8'h30; end
        e.val = e.val * 10 + 32'(c - 8'h30);
        kept.push_back(c);
      end
      if (src == 0) q0.push_back({i == n - 1, cur[i]});
      else          q1.push_back({i == n - 1, cur[i]});
    end
    pad = D - kept.size();
    for (int p = 0; p < D; p++) e.strm = {e.strm[55:0], (p < pad) ? 8'h30 : kept[p - pad]};
    if (src == 0) e0.push_back(e);
    else          e1.push_back(e);
  endtask

  task automatic compare_result(input int id, input string tag);
    exp_t e;
    logic [63:0] s = '0;
    if ((id == 0 ? e0.size() : e1.size()) == 0) begin
      chk({tag, ".have_expect"}, 64'd0, 64'd1);
      return;
    end
    if (id == 0) e = e0.pop_front();
    else         e = e1.pop_front();
    foreach (conv_seen[i]) s = {s[55:0], conv_seen[i]};
    chk({tag, ".id"},   64'(res_id),  64'(id));
    chk({tag, ".data"}, 64'(res_data), 64'(e.val));
    chk({tag, ".err"},  64'(res_err), 64'(e.err));
    chk({tag, ".stream_len"}, 64'(conv_seen.size()), 64'(D));
    chk({tag, ".stream"}, s, e.strm);
    conv_seen.delete();
  endtask

  task automatic check_result(input int id, input string tag);
    int t = 0;
    @(negedge clk); #1;
    while (!res_valid && t < 400) begin @(negedge clk); #1; t++; end
    chk({tag, ".timeout"}, 64'(res_valid), 64'd1);
    if (!res_valid) return;
    res_cyc = cyc;
    compare_result(id, tag);
    if (res_ready) begin
      @(negedge clk); #1;
      chk({tag, ".pulse"}, 64'(res_valid), 64'd0);
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.conv_valid", 64'(conv_valid), 64'd0);
    chk("rst.conv_char", 64'(conv_char), 64'd0);
    chk("rst.res_valid", 64'(res_valid), 64'd0);
    chk("rst.res_data", 64'(res_data), 64'd0);
    chk("rst.res_id", 64'(res_id), 64'd0);
    chk("rst.res_err", 64'(res_err), 64'd0);
    rst_n = 1'b1;

    load_str("42"); enqueue(0);
    load_str("7");  enqueue(1);
    check_result(0, "rr_first");
    check_result(1, "rr_second");

    load_str("123"); enqueue(0);
    load_str("9");   enqueue(1);
    check_result(0, "pad_123");
    chk("latency", 64'(res_cyc - last_acc_cyc), 64'(D + CL + 1));
    check_result(1, "single_9");

    load_str("123456789"); enqueue(1);
    check_result(1, "overflow");
    load_str("1A3"); enqueue(0);
    check_result(0, "non_digit");
    load_str("99999999"); enqueue(0);
    check_result(0, "full_width");

    conv_busy = 1'b1;
    load_str("5"); enqueue(0);
    repeat (6) begin
      @(negedge clk); #1;
      chk("busy.req_ready", 64'(req_ready), 64'd0);
      chk("busy.conv_valid", 64'(conv_valid), 64'd0);
    end
    conv_busy = 1'b0;
    check_result(0, "busy_release");

    res_ready = 1'b0;
    load_str("77"); enqueue(0);
    t = 0;
    @(negedge clk); #1;
    while (!res_valid && t < 400) begin @(negedge clk); #1; t++; end
    chk("hold.timeout", 64'(res_valid), 64'd1);
    load_str("31"); enqueue(1);
    compare_result(0, "hold_first");
    repeat (10) begin
      @(negedge clk); #1;
      chk("hold.res_valid", 64'(res_valid), 64'd1);
      chk("hold.res_data", 64'(res_data), 64'd77);
      chk("hold.res_id", 64'(res_id), 64'd0);
      chk("hold.req_ready", 64'(req_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk); #1;
    chk("hold.released", 64'(res_valid), 64'd0);
    chk("hold.idle_ready", 64'(req_ready), 64'd0);
    @(negedge clk); #1;
    chk("hold.grant_src1", 64'(req_ready), 64'd2);
    check_result(1, "hold_second");

    stall_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int src;
      src = $urandom_range(0, 1);
      gen_random();
      enqueue(src);
      check_result(src, "rand");
    end
    stall_en = 1'b0;

    load_str("987"); enqueue(0);
    t = 0;
    while (!conv_valid && t < 100) begin @(negedge clk); #1; t++; end
    chk("rst_mid.reach_stream", 64'(conv_valid), 64'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.conv_valid", 64'(conv_valid), 64'd0);
    chk("rst_mid.conv_char", 64'(conv_char), 64'd0);
    chk("rst_mid.res_valid", 64'(res_valid), 64'd0);
    chk("rst_mid.res_data", 64'(res_data), 64'd0);
    chk("rst_mid.req_ready", 64'(req_ready), 64'd0);
    e0.delete(); e1.delete(); q0.delete(); q1.delete(); conv_seen.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    load_str("5"); enqueue(1);
    check_result(1, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
